// File: rtl/accum_seq_pkg.sv
// Shared types and default sizes for the burst accumulator.
package accum_seq_pkg;

  localparam int WIDTH_D = 8;
  localparam int CNT_W_D = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/accum_seq8_sat_add.sv
// One-step accumulate: WIDTH+1-bit add with optional clamp to all-ones on carry-out.
module sat_add #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[WIDTH];
  // An all-ones accumulator plus any non-zero sample carries again, so saturation is self-holding.
  assign sum   = (SAT && carry) ? {WIDTH{1'b1}} : full[WIDTH-1:0];

endmodule

// File: rtl/accum_seq8.sv
// Burst accumulator: sums N samples over a valid/ready input, then strobes done with the total.
module accum_seq8
  import accum_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [CNT_W-1:0] N,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             done,
  output state_t           dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on state, and an unaccepted sample must be held by the upstream.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic               ovf_int_q;
  logic [WIDTH-1:0]   result_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;
  logic               xfer;
  logic               last_xfer;

  sat_add #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_sat_add (
    .a     (acc_q),
    .b     (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign xfer      = (state_q == ACCUM) && in_valid;
  assign last_xfer = xfer && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (N == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last_xfer) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_int_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= N;
            acc_q     <= '0;
            ovf_int_q <= 1'b0;
            if (N == '0) begin
              result_q <= '0;
              ovf_q    <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_q     <= add_sum;
            ovf_int_q <= ovf_int_q | add_carry;
            cnt_q     <= cnt_q - CNT_W'(1);
            // Publish on the DONE entry edge so result/ovf are stable while done is high.
            if (last_xfer) begin
              result_q <= add_sum;
              ovf_q    <= ovf_int_q | add_carry;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
